// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite slave memory: response codes and FSM state encodings.
package axil_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only word-aligned accesses are serviced; anything else is answered with SLVERR.
  function automatic logic addr_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/axil_regbank.sv
// Word-addressed storage with a byte-strobed write port and a registered read port.
// A write and a read of the same word on the same edge returns the pre-write contents.
module axil_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic                       re_i,
  input  logic                       rzero_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Merge strobed write bytes into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wstrb_i[b]) begin
          mem_d[waddr_i][8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured from the current contents; rzero forces an error read to zero.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  // Storage and read register, both cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_slave_mem.sv
// AXI-Lite slave backed by a small word memory. Independent write (AW/W/B) and read (AR/R)
// state machines; misaligned addresses get SLVERR and never touch storage.
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RespOkay   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] RespSlverr = RESP_WIDTH'(RESP_SLVERR);

  // Decoded views of the live address buses.
  logic            aw_err, ar_err;
  logic [IdxW-1:0] aw_idx, ar_idx;

  assign aw_err = addr_misaligned(s_axi_awaddr[1:0]);
  assign aw_idx = s_axi_awaddr[2 +: IdxW];
  assign ar_err = addr_misaligned(s_axi_araddr[1:0]);
  assign ar_idx = s_axi_araddr[2 +: IdxW];

  // Upper address bits are decoded upstream and the extra strobe bit is meaningless.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

  // ---------------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [IdxW-1:0]       awidx_q, awidx_d;
  logic                  awerr_q, awerr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

  logic                  commit;
  logic [IdxW-1:0]       cm_idx;
  logic                  cm_err;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [NB-1:0]         cm_strb;

  // Write FSM: collect AW and W in either order, commit on the edge completing the pair.
  always_comb begin
    wr_state_d    = wr_state_q;
    awidx_d       = awidx_q;
    awerr_d       = awerr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bresp_d       = bresp_q;
    commit        = 1'b0;
    cm_idx        = awidx_q;
    cm_err        = awerr_q;
    cm_data       = wdata_q;
    cm_strb       = wstrb_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;

    unique case (wr_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          commit     = 1'b1;
          cm_idx     = aw_idx;
          cm_err     = aw_err;
          cm_data    = s_axi_wdata;
          cm_strb    = s_axi_wstrb[NB-1:0];
          wr_state_d = W_RESP;
        end else if (s_axi_awvalid) begin
          awidx_d    = aw_idx;
          awerr_d    = aw_err;
          wr_state_d = W_HAVE_ADDR;
        end else if (s_axi_wvalid) begin
          wdata_d    = s_axi_wdata;
          wstrb_d    = s_axi_wstrb[NB-1:0];
          wr_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          commit     = 1'b1;
          cm_data    = s_axi_wdata;
          cm_strb    = s_axi_wstrb[NB-1:0];
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          commit     = 1'b1;
          cm_idx     = aw_idx;
          cm_err     = aw_err;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (commit) begin
      bresp_d = cm_err ? RespSlverr : RespOkay;
    end
  end

  // Write channel registers.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_q <= W_IDLE;
      awidx_q    <= '0;
      awerr_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awidx_q    <= awidx_d;
      awerr_q    <= awerr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  assign s_axi_bresp = bresp_q;

  // ---------------------------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic                  rd_en;

  // Read FSM: accept AR in idle, present registered data until the master takes it.
  always_comb begin
    rd_state_d    = rd_state_q;
    rresp_d       = rresp_q;
    rd_en         = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;

    unique case (rd_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          rd_en      = 1'b1;
          rresp_d    = ar_err ? RespSlverr : RespOkay;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state_q <= R_IDLE;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_rresp = rresp_q;

  axil_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regbank (
    .clk_i   (s_axi_aclk),
    .rst_i   (s_axi_areset),
    .we_i    (commit && !cm_err),
    .waddr_i (cm_idx),
    .wdata_i (cm_data),
    .wstrb_i (cm_strb),
    .re_i    (rd_en),
    .rzero_i (ar_err),
    .raddr_i (ar_idx),
    .rdata_o (s_axi_rdata)
  );

endmodule

// File: tb/tb_axil_slave_mem.sv
// Self-checking bench for axil_slave_mem: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_axil_slave_mem;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        wvalid, wready;
  logic [2:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [16];

  always #5 clk = ~clk;

  axil_slave_mem dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expected_read(input logic [7:0] addr);
    if (addr[1:0] != 2'b00) return 32'h0;
    return model[addr[5:2]];
  endfunction

  // Reference model update: unaligned writes are dropped, otherwise strobed bytes replace old ones.
  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb);
    if (addr[1:0] == 2'b00) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                          input int mode, input int gap, input int bstall);
    logic [2:0] exp_resp;
    int n;
    exp_resp = (addr[1:0] != 2'b00) ? 3'd2 : 3'd0;
    if (mode == 0) begin
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; awaddr = 8'($urandom); wdata = $urandom;
    end else if (mode == 1) begin
      awaddr = addr; awvalid = 1'b1;
      tick();
      awvalid = 1'b0; awaddr = 8'($urandom);
      for (int i = 0; i < gap; i++) begin
        checks++;
        if ({awready, wready, bvalid} !== 3'b010) begin
          errors++;
          $display("FAIL have_addr_ready got aw/w/b=%b required 010", {awready, wready, bvalid});
        end
        tick();
      end
      wdata = data; wstrb = strb; wvalid = 1'b1;
      tick();
      wvalid = 1'b0; wdata = $urandom;
    end else begin
      wdata = data; wstrb = strb; wvalid = 1'b1;
      tick();
      wvalid = 1'b0; wdata = $urandom; wstrb = 5'($urandom);
      for (int i = 0; i < gap; i++) begin
        checks++;
        if ({awready, wready, bvalid} !== 3'b100) begin
          errors++;
          $display("FAIL have_data_ready got aw/w/b=%b required 100", {awready, wready, bvalid});
        end
        tick();
      end
      awaddr = addr; awvalid = 1'b1;
      tick();
      awvalid = 1'b0; awaddr = 8'($urandom);
    end
    model_write(addr, data, strb);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL bvalid_after_commit got %b required 1", bvalid);
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    end
    checks++;
    if (bresp !== exp_resp) begin
      errors++;
      $display("FAIL bresp addr=%h got %0d required %0d", addr, bresp, exp_resp);
    end
    for (int i = 0; i < bstall; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, exp_resp, 2'b00}) begin
        errors++;
        $display("FAIL b_stall cycle %0d got b/resp/aw/w=%b/%0d/%b/%b required 1/%0d/0/0",
                 i, bvalid, bresp, awready, wready, exp_resp);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++;
      $display("FAIL b_done got b/aw/w=%b required 011", {bvalid, awready, wready});
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int rstall);
    logic [31:0] exp_data;
    logic [2:0]  exp_resp;
    exp_data = expected_read(addr);
    exp_resp = (addr[1:0] != 2'b00) ? 3'd2 : 3'd0;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL arready_idle got %b required 1", arready);
    end
    araddr = addr; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; araddr = 8'($urandom);
    checks++;
    if ({rvalid, arready} !== 2'b10) begin
      errors++;
      $display("FAIL r_latency got rvalid/arready=%b required 10", {rvalid, arready});
    end
    checks++;
    if (rdata !== exp_data || rresp !== exp_resp) begin
      errors++;
      $display("FAIL read addr=%h got %h/%0d required %h/%0d", addr, rdata, rresp, exp_data,
               exp_resp);
    end
    for (int i = 0; i < rstall; i++) begin
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp) begin
        errors++;
        $display("FAIL r_stall got %b/%h/%0d required 1/%h/%0d", rvalid, rdata, rresp, exp_data,
                 exp_resp);
      end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL r_done got rvalid/arready=%b required 01", {rvalid, arready});
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100 || bresp !== 3'd0 ||
        rresp !== 3'd0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s got aw/w/ar/b/r=%b bresp=%0d rresp=%0d rdata=%h required 11100 0 0 0",
               tag, {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    tick(); tick();
    areset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check_idle_after_reset("reset_state");
    do_read(8'h00, 0);
    do_read(8'h3C, 0);
  endtask

  task automatic test_basic();
    do_write(8'h00, 32'd56, 5'h0F, 0, 0, 0);
    do_read(8'h00, 0);
  endtask

  task automatic test_strobe();
    do_write(8'h04, 32'h11223344, 5'h0F, 0, 0, 0);
    do_write(8'h04, 32'hAABBCCDD, 5'h03, 0, 0, 0);
    checks++;
    if (model[1] !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL strobe_model got %h required 1122ccdd", model[1]);
    end
    do_read(8'h04, 1);
  endtask

  task automatic test_w_first();
    do_write(8'h08, 32'd7, 5'h0F, 2, 3, 0);
    do_read(8'h08, 0);
    do_write(8'h10, 32'hCAFEF00D, 5'h0F, 1, 3, 0);
    do_read(8'h10, 0);
  endtask

  task automatic test_slverr();
    do_write(8'h02, 32'd9, 5'h0F, 0, 0, 0);
    do_read(8'h00, 0);
    do_read(8'h02, 0);
  endtask

  task automatic test_bready_stall();
    do_write(8'h14, 32'h0BADBEEF, 5'h0F, 0, 0, 5);
    do_write(8'h17, 32'h12345678, 5'h0F, 1, 1, 5);
  endtask

  // Read and write hit the same word on the same edge: read sees the old contents.
  task automatic test_concurrent();
    logic [31:0] old_val;
    old_val = model[1];
    awaddr = 8'h04; wdata = 32'h5A5A5A5A; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(8'h04, 32'h5A5A5A5A, 5'h0F);
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_val) begin
      errors++;
      $display("FAIL concurrent_read got %b/%h required 1/%h", rvalid, rdata, old_val);
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 3'd0) begin
      errors++;
      $display("FAIL concurrent_write got %b/%0d required 1/0", bvalid, bresp);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(8'h04, 0);
  endtask

  task automatic test_reset_mid();
    do_write(8'h0C, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
    do_read(8'h0C, 0);
    awaddr = 8'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if ({awready, wready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_have_addr got aw/w=%b required 01", {awready, wready});
    end
    wdata = 32'h77777777; wstrb = 5'h0F; wvalid = 1'b1; areset = 1'b1;
    tick();
    wvalid = 1'b0; areset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check_idle_after_reset("reset_mid_state");
    tick();
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_resp got bvalid=%b required 0", bvalid);
    end
    do_read(8'h0C, 0);
    do_read(8'h00, 0);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d;
    for (int it = 0; it < 80; it++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        do_write(a, d, 5'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));
      end else begin
        do_read(a, int'($urandom_range(0, 2)));
      end
    end
    for (int i = 0; i < 16; i++) do_read(8'(i * 4), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_w_first();
    test_slverr();
    test_bready_stall();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave_mem.md
AXIL_SLAVE_MEM -- requirements
Module: axil_slave_mem

Interface
REQ-001 SHALL be clocked by one clock, s_axi_aclk; reset s_axi_areset is synchronous and active-high.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, byte address width.
REQ-004 SHALL have parameter RESP_WIDTH, default 3, response width.
REQ-005 SHALL have parameter DEPTH, default 16, number of words (power of 2).
REQ-006 SHALL have s_axi_aclk  in  1  clock.
REQ-007 SHALL have s_axi_areset  in  1  sync reset, active-high.
REQ-008 SHALL have s_axi_awaddr  in  ADDR_WIDTH  write byte address.
REQ-009 SHALL have s_axi_awvalid  in  1  / s_axi_awready  out  1  AW handshake.
REQ-010 SHALL have s_axi_wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit [DATA_WIDTH/8] ignored.
REQ-012 SHALL have s_axi_wvalid  in  1  / s_axi_wready  out  1  W handshake.
REQ-013 SHALL have s_axi_bresp  out  RESP_WIDTH  write response.
REQ-014 SHALL have s_axi_bvalid  out  1  / s_axi_bready  in  1  B handshake.
REQ-015 SHALL have s_axi_araddr  in  ADDR_WIDTH  read byte address.
REQ-016 SHALL have s_axi_arvalid  in  1  / s_axi_arready  out  1  AR handshake.
REQ-017 SHALL have s_axi_rdata  out  DATA_WIDTH  / s_axi_rresp  out  RESP_WIDTH  read data, response.
REQ-018 SHALL have s_axi_rvalid  out  1  / s_axi_rready  in  1  R handshake.

Function
REQ-019 SHALL index words by addr[2 +: log2(DEPTH)]; higher bits ignored (upstream bus decodes).
REQ-020 SHALL respond SLVERR (2) when addr[1:0] != 0, else OKAY (0); SLVERR writes SHALL not modify memory, SLVERR reads return rdata 0.
REQ-021 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-022 W_IDLE: awready=wready=1; AW+W same edge -> commit, W_RESP; AW only -> W_HAVE_ADDR; W only -> W_HAVE_DATA.
REQ-023 W_HAVE_ADDR: only wready=1; W_HAVE_DATA: only awready=1; completing handshake -> commit, W_RESP.
REQ-024 Commit SHALL update only bytes with wstrb[i]=1, on the edge completing the second handshake.
REQ-025 W_RESP: bvalid=1 with bresp stable; awready=wready=0; bvalid&bready -> W_IDLE.
REQ-026 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1, arready=0).
REQ-027 AR handshake SHALL register rdata/rresp on that edge; rvalid asserts next cycle (latency 1); held stable until rready.
REQ-028 Read and write committing same word on same edge: read SHALL return pre-write data.
REQ-029 Read and write FSMs SHALL run independently and concurrently.

Reset
REQ-030 On s_axi_areset=1 at an edge: both FSMs idle, awready=wready=arready=1 next cycle, bvalid=rvalid=0, bresp=rresp=0, rdata=0; mid-transaction captures discarded.
REQ-031 Memory contents SHALL be cleared to 0 by reset.

Structure
REQ-032 Package axil_pkg SHALL hold RESP_OKAY=0, RESP_SLVERR=2, FSM state encodings.
REQ-033 Storage SHALL be sub-module axil_regbank (byte-strobed write port, registered read port).

Verification
REQ-034 AW+W addr 0x00, data 56, wstrb 0xF same cycle; read 0x00 -> bresp 0, rdata 56, rresp 0, rvalid one cycle after AR.
REQ-035 Write 0x11223344 to 0x04, then 0xAABBCCDD wstrb 0x3 -> read 0x04 returns 0x1122CCDD.
REQ-036 W 3 cycles before AW (addr 0x08, data 7) -> awready only in W_HAVE_DATA, bvalid after AW, read returns 7.
REQ-037 Write 0x02 data 9 -> bresp 2, word 0 unchanged; read 0x02 -> rresp 2, rdata 0.
REQ-038 bready low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; reset during W_HAVE_ADDR -> no commit, outputs per REQ-030.
